// File: rtl/riscv_fd_pkg.sv
// riscv_fd_pkg: shared types and constants for the fetch-to-decode queue.
//   fd_entry_t  : one buffered fetch beat plus the rs1/imm12 fields
//                 pre-sliced at enqueue so decode reads them from flops.
//   FD_*_LSB/MSB: bit positions of rs1 and the I-type immediate.
package riscv_fd_pkg;

    localparam int FD_XLEN  = 64;
    localparam int FD_ILEN  = 32;
    localparam int FD_CILEN = 16;

    localparam int FD_RS1_LSB   = 15;
    localparam int FD_RS1_MSB   = 19;
    localparam int FD_IMM12_LSB = 20;
    localparam int FD_IMM12_MSB = 31;

    typedef struct packed {
        logic [FD_XLEN-1:0]  pc;
        logic [FD_XLEN-1:0]  pcplus;
        logic [FD_ILEN-1:0]  inst;
        logic [FD_CILEN-1:0] cinst;
        logic                cillegal;
        logic [4:0]          rs1;
        logic [11:0]         imm12;
    } fd_entry_t;

endpackage

// File: rtl/riscv_fd_queue.sv
// riscv_fd_queue: DEPTH-entry circular buffer between fetch and decode.
//   Clock/reset : i_riscv_fd_clk (rising), i_riscv_fd_rst (async, active-high)
//   Flush       : i_riscv_fd_flush empties the queue on the next edge
//   Fetch side  : i_riscv_fd_valid_f / o_riscv_fd_ready_f plus pc, pcplus,
//                 inst, cinst, cillegal_inst
//   Decode side : o_riscv_fd_valid_d / i_riscv_fd_ready_d plus the head
//                 entry fields, rs1 and constimm12
//   Status      : o_riscv_fd_count occupancy
module riscv_fd_queue
    import riscv_fd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = FD_XLEN,
    parameter int ILEN  = FD_ILEN,
    parameter int CILEN = FD_CILEN
) (
    input  logic                       i_riscv_fd_clk,
    input  logic                       i_riscv_fd_rst,
    input  logic                       i_riscv_fd_flush,
    input  logic                       i_riscv_fd_valid_f,
    output logic                       o_riscv_fd_ready_f,
    input  logic [XLEN-1:0]            i_riscv_fd_pc_f,
    input  logic [XLEN-1:0]            i_riscv_fd_pcplus_f,
    input  logic [ILEN-1:0]            i_riscv_fd_inst_f,
    input  logic [CILEN-1:0]           i_riscv_fd_cinst_f,
    input  logic                       i_riscv_fd_cillegal_inst_f,
    output logic                       o_riscv_fd_valid_d,
    input  logic                       i_riscv_fd_ready_d,
    output logic [XLEN-1:0]            o_riscv_fd_pc_d,
    output logic [XLEN-1:0]            o_riscv_fd_pcplus_d,
    output logic [ILEN-1:0]            o_riscv_fd_inst_d,
    output logic [CILEN-1:0]           o_riscv_fd_cinst_d,
    output logic                       o_riscv_fd_cillegal_inst_d,
    output logic [4:0]                 o_riscv_fd_rs1_d,
    output logic [11:0]                o_riscv_fd_constimm12_d,
    output logic [$clog2(DEPTH+1)-1:0] o_riscv_fd_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fd_entry_t         mem [DEPTH];
    fd_entry_t         new_entry;
    fd_entry_t         head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              enq;
    logic              deq;

    // ready_f depends only on registered occupancy, so a full queue refuses
    // fetch even when decode drains it in the same cycle.
    assign o_riscv_fd_ready_f = (count != FULL);
    assign o_riscv_fd_valid_d = (count != '0);
    assign o_riscv_fd_count   = count;

    assign enq = i_riscv_fd_valid_f && o_riscv_fd_ready_f && !i_riscv_fd_flush;
    assign deq = o_riscv_fd_valid_d && i_riscv_fd_ready_d && !i_riscv_fd_flush;

    always_comb begin
        new_entry          = '0;
        new_entry.pc       = i_riscv_fd_pc_f;
        new_entry.pcplus   = i_riscv_fd_pcplus_f;
        new_entry.inst     = i_riscv_fd_inst_f;
        new_entry.cinst    = i_riscv_fd_cinst_f;
        new_entry.cillegal = i_riscv_fd_cillegal_inst_f;
        new_entry.rs1      = i_riscv_fd_inst_f[FD_RS1_MSB:FD_RS1_LSB];
        new_entry.imm12    = i_riscv_fd_inst_f[FD_IMM12_MSB:FD_IMM12_LSB];
    end

    always_ff @(posedge i_riscv_fd_clk or posedge i_riscv_fd_rst) begin
        if (i_riscv_fd_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_riscv_fd_flush) begin
            // storage is left as-is; zeroed count makes it unreachable
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty queue presents an all-zero bubble on the data outputs.
    assign head = o_riscv_fd_valid_d ? mem[rd_ptr] : '0;

    assign o_riscv_fd_pc_d            = head.pc;
    assign o_riscv_fd_pcplus_d        = head.pcplus;
    assign o_riscv_fd_inst_d          = head.inst;
    assign o_riscv_fd_cinst_d         = head.cinst;
    assign o_riscv_fd_cillegal_inst_d = head.cillegal;
    assign o_riscv_fd_rs1_d           = head.rs1;
    assign o_riscv_fd_constimm12_d    = head.imm12;

endmodule

// File: tb/tb_riscv_fd_queue.sv
// tb_riscv_fd_queue: directed vectors with a scoreboard queue of expected
// decode-side entries; a negedge monitor compares status every cycle and the
// head entry whenever the queue is non-empty.
module tb_riscv_fd_queue;

    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pcplus;
        logic [31:0] inst;
        logic [15:0] cinst;
        logic        cill;
        logic [4:0]  rs1;
        logic [11:0] imm;
    } exp_t;

    // Hand-decoded rs1 = inst[19:15], imm12 = inst[31:20].
    logic [31:0] tv_inst [10] = '{32'h00500093, 32'h00A10113, 32'hFFF28293,
                                  32'h12345678, 32'h800F8F13, 32'h7FF00013,
                                  32'hDEADBEEF, 32'h00C58593, 32'h00000013,
                                  32'h00500093};
    logic [4:0]  tv_rs1  [10] = '{5'd0, 5'd2, 5'd5, 5'd8, 5'd31,
                                  5'd0, 5'd27, 5'd11, 5'd0, 5'd0};
    logic [11:0] tv_imm  [10] = '{12'h005, 12'h00A, 12'hFFF, 12'h123, 12'h800,
                                  12'h7FF, 12'hDEA, 12'h00C, 12'h000, 12'h005};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        valid_f = 1'b0;
    logic        ready_f;
    logic [63:0] pc_f = '0;
    logic [63:0] pcplus_f = '0;
    logic [31:0] inst_f = '0;
    logic [15:0] cinst_f = '0;
    logic        cill_f = 1'b0;
    logic        valid_d;
    logic        ready_d = 1'b0;
    logic [63:0] pc_d;
    logic [63:0] pcplus_d;
    logic [31:0] inst_d;
    logic [15:0] cinst_d;
    logic        cill_d;
    logic [4:0]  rs1_d;
    logic [11:0] imm_d;
    logic [1:0]  count;

    int   cur_idx = 0;
    int   applied = 0;
    int   miscompares = 0;
    int   mcount = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    riscv_fd_queue #(.DEPTH(DEPTH)) dut (
        .i_riscv_fd_clk             (clk),
        .i_riscv_fd_rst             (rst),
        .i_riscv_fd_flush           (flush),
        .i_riscv_fd_valid_f         (valid_f),
        .o_riscv_fd_ready_f         (ready_f),
        .i_riscv_fd_pc_f            (pc_f),
        .i_riscv_fd_pcplus_f        (pcplus_f),
        .i_riscv_fd_inst_f          (inst_f),
        .i_riscv_fd_cinst_f         (cinst_f),
        .i_riscv_fd_cillegal_inst_f (cill_f),
        .o_riscv_fd_valid_d         (valid_d),
        .i_riscv_fd_ready_d         (ready_d),
        .o_riscv_fd_pc_d            (pc_d),
        .o_riscv_fd_pcplus_d        (pcplus_d),
        .o_riscv_fd_inst_d          (inst_d),
        .o_riscv_fd_cinst_d         (cinst_d),
        .o_riscv_fd_cillegal_inst_d (cill_d),
        .o_riscv_fd_rs1_d           (rs1_d),
        .o_riscv_fd_constimm12_d    (imm_d),
        .o_riscv_fd_count           (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs change at posedge+1 and are held for one full cycle.
    task automatic drive(input logic vf, input int idx, input logic rd, input logic fl);
        valid_f  = vf;
        cur_idx  = idx;
        pc_f     = 64'h1000 + 64'(idx * 4);
        pcplus_f = (idx % 2 == 1) ? 64'h1000 + 64'(idx * 4) + 64'd2
                                  : 64'h1000 + 64'(idx * 4) + 64'd4;
        inst_f   = tv_inst[idx];
        cinst_f  = (idx % 2 == 1) ? 16'h4500 + 16'(idx) : 16'h0000;
        cill_f   = (idx == 7);
        ready_d  = rd;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare current outputs against the model, then advance the
    // model by what the next rising edge will do with the held inputs.
    always @(negedge clk) begin
        if (rst) begin
            mcount = 0;
            sb.delete();
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_valid_d", 64'(valid_d), 64'd0);
            chk("rst_ready_f", 64'(ready_f), 64'd1);
        end else begin
            logic enq, deq;
            exp_t e;
            chk("count", 64'(count), 64'(mcount));
            chk("valid_d", 64'(valid_d), 64'(mcount != 0));
            chk("ready_f", 64'(ready_f), 64'(mcount != DEPTH));
            if (mcount != 0 && sb.size() > 0) begin
                chk("head_pc", pc_d, sb[0].pc);
                chk("head_pcplus", pcplus_d, sb[0].pcplus);
                chk("head_inst", 64'(inst_d), 64'(sb[0].inst));
                chk("head_cinst", 64'(cinst_d), 64'(sb[0].cinst));
                chk("head_cill", 64'(cill_d), 64'(sb[0].cill));
                chk("head_rs1", 64'(rs1_d), 64'(sb[0].rs1));
                chk("head_imm12", 64'(imm_d), 64'(sb[0].imm));
            end else begin
                chk("bubble_pc", pc_d, 64'd0);
                chk("bubble_inst", 64'(inst_d), 64'd0);
                chk("bubble_imm12", 64'(imm_d), 64'd0);
            end
            if (flush) begin
                sb.delete();
                mcount = 0;
            end else begin
                deq = (mcount != 0) && ready_d;
                enq = valid_f && (mcount != DEPTH);
                if (deq && sb.size() > 0) void'(sb.pop_front());
                if (enq) begin
                    e.pc     = pc_f;
                    e.pcplus = pcplus_f;
                    e.inst   = inst_f;
                    e.cinst  = cinst_f;
                    e.cill   = cill_f;
                    e.rs1    = tv_rs1[cur_idx];
                    e.imm    = tv_imm[cur_idx];
                    sb.push_back(e);
                end
                mcount = mcount + (enq ? 1 : 0) - (deq ? 1 : 0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // fill with decode stalled; third beat refused twice
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 2, 0, 0);
        drive(1, 2, 0, 0);
        // full with fetch and decode both active: dequeue only
        drive(1, 2, 1, 0);
        // now accepted
        drive(1, 2, 0, 0);

        // flush with full queue, fetch and decode both active
        drive(1, 3, 1, 1);
        drive(1, 4, 0, 0);
        drive(0, 4, 1, 0);
        drive(0, 0, 0, 0);

        // streaming ten beats with decode always ready
        for (int i = 0; i < 10; i++) drive(1, i, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);

        // async reset between edges while streaming
        drive(1, 5, 1, 0);
        drive(1, 6, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_valid_d", 64'(valid_d), 64'd0);
        chk("async_ready_f", 64'(ready_f), 64'd1);
        chk("async_pc_d", pc_d, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        valid_f = 1'b0;
        drive(0, 0, 0, 0);
        drive(1, 7, 0, 0);
        drive(1, 8, 1, 0);
        drive(1, 9, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
